// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame-format limits and bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DELIVER
  } uart_rx_state_t;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;
  // Below this many clocks per bit the three centre samples no longer fit inside the bit.
  localparam int unsigned CYCLE_MIN     = 8;

  // Clocks per bit period; clk_fre is in MHz.
  function automatic int unsigned calc_cycle(input int unsigned clk_fre, input int unsigned baud);
    return (clk_fre * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, falling-edge detect and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CYCLE = 10,
  parameter int unsigned CNT_W = $clog2(CYCLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_pin,
  input  logic [CNT_W-1:0] cycle_cnt,
  output logic             fall_edge,
  output logic             bit_val,
  output logic             bit_strobe
);

  localparam logic [CNT_W-1:0] SAMP_0 = CNT_W'(CYCLE / 2 - 1);
  localparam logic [CNT_W-1:0] SAMP_1 = CNT_W'(CYCLE / 2);
  localparam logic [CNT_W-1:0] SAMP_2 = CNT_W'(CYCLE / 2 + 1);

  logic sync_1, sync_2, sync_prev;
  logic samp_0, samp_1;

  // Synchronise the pin, keep last value for edge detect, capture the first two votes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      sync_prev <= 1'b1;
      samp_0    <= 1'b1;
      samp_1    <= 1'b1;
    end else begin
      sync_1    <= rx_pin;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      if (cycle_cnt == SAMP_0) samp_0 <= sync_2;
      if (cycle_cnt == SAMP_1) samp_1 <= sync_2;
    end
  end

  // Third vote is the live synchronised value, so the decision lands on SAMP_2 itself.
  assign fall_edge  = sync_prev & ~sync_2;
  assign bit_strobe = (cycle_cnt == SAMP_2);
  assign bit_val    = (samp_0 & samp_1) | (samp_0 & sync_2) | (samp_1 & sync_2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1 or 2 stop bits,
// majority-voted sampling and a single holding register with valid/ready handshake.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 27,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(CYCLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = 1'(PARITY_ODD);

  if (CYCLE < CYCLE_MIN) begin : g_bad_cycle
    $error("uart_rx_cfg: CLK_FRE/BAUD_RATE gives fewer than 8 clocks per bit");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  uart_rx_state_t       state;
  logic [CNT_W-1:0]     cycle_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] rx_bits;
  logic                 par_bit;
  logic                 stop_bad;
  logic                 fall_edge, bit_val, bit_strobe;
  logic                 hold_full;
  logic                 par_mismatch;

  uart_rx_sampler #(
    .CYCLE (CYCLE),
    .CNT_W (CNT_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_pin     (rx_pin),
    .cycle_cnt  (cycle_cnt),
    .fall_edge  (fall_edge),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe)
  );

  // A word being accepted this cycle frees the holding register for a same-cycle load.
  assign hold_full    = rx_data_valid & ~rx_data_ready;
  assign par_mismatch = (PARITY_EN != 0) && ((^rx_bits ^ par_bit) != PAR_ODD);

  // Frame FSM, bit-period counters and the holding register with its flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cycle_cnt     <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      rx_bits       <= '0;
      par_bit       <= 1'b0;
      stop_bad      <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_data_valid && rx_data_ready) rx_data_valid <= 1'b0;
      cycle_cnt <= (cycle_cnt == CNT_LAST) ? '0 : cycle_cnt + 1'b1;

      unique case (state)
        S_IDLE: begin
          cycle_cnt <= '0;
          bit_cnt   <= '0;
          stop_cnt  <= 1'b0;
          stop_bad  <= 1'b0;
          if (fall_edge) state <= S_START;
        end
        S_START: begin
          if (bit_strobe && bit_val) begin
            // Line back high at mid start bit: a glitch, not a frame.
            state     <= S_IDLE;
            cycle_cnt <= '0;
          end else if (cycle_cnt == CNT_LAST) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_strobe) rx_bits[bit_cnt] <= bit_val;
          if (cycle_cnt == CNT_LAST) begin
            if (bit_cnt == BIT_LAST) begin
              state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_strobe) par_bit <= bit_val;
          if (cycle_cnt == CNT_LAST) state <= S_STOP;
        end
        S_STOP: begin
          if (bit_strobe) begin
            if (!bit_val) stop_bad <= 1'b1;
            // Leave on the final stop bit's centre so a back-to-back start edge is seen.
            if (stop_cnt == STOP_LAST) begin
              state     <= S_DELIVER;
              cycle_cnt <= '0;
            end
          end else if (cycle_cnt == CNT_LAST) begin
            stop_cnt <= 1'b1;
          end
        end
        S_DELIVER: begin
          if (hold_full) begin
            overrun_err <= 1'b1;
          end else begin
            rx_data       <= rx_bits;
            parity_err    <= par_mismatch;
            frame_err     <= stop_bad;
            rx_data_valid <= 1'b1;
          end
          state     <= S_IDLE;
          cycle_cnt <= '0;
        end
        default: begin
          state     <= S_IDLE;
          cycle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) driven by directed and random frames,
// received words checked against a frame-level reference model.
`timescale 1ns / 1ps
module tb_uart_rx_cfg;

  localparam int CYC     = 10;  // 1 MHz / 100 kbaud
  localparam int PAR_ODD = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_p, rx_s;
  logic       ready_a, ready_p, ready_s;
  logic [7:0] data_a, data_p;
  logic [6:0] data_s;
  logic       valid_a, valid_p, valid_s;
  logic       perr_a, perr_p, perr_s;
  logic       ferr_a, ferr_p, ferr_s;
  logic       ovr_a, ovr_p, ovr_s;

  int   checks   = 0;
  int   failures = 0;
  int   vcyc_a   = 0;
  int   ovr_cnt  = 0;
  rec_t got_q[$];
  rec_t exp_q[$];

  always #500 clk = ~clk;

  uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(100000)) dut_a (
    .clk(clk), .rst(rst), .rx_pin(rx_a), .rx_data(data_a), .rx_data_valid(valid_a),
    .rx_data_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a)
  );
  uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY_EN(1), .PARITY_ODD(PAR_ODD)) dut_p (
    .clk(clk), .rst(rst), .rx_pin(rx_p), .rx_data(data_p), .rx_data_valid(valid_p),
    .rx_data_ready(ready_p), .parity_err(perr_p), .frame_err(ferr_p), .overrun_err(ovr_p)
  );
  uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .rx_pin(rx_s), .rx_data(data_s), .rx_data_valid(valid_s),
    .rx_data_ready(ready_s), .parity_err(perr_s), .frame_err(ferr_s), .overrun_err(ovr_s)
  );

  // Record every accepted word and count overrun pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid_a && ready_a) got_q.push_back({2'd0, 1'b0, data_a, perr_a, ferr_a});
    if (valid_p && ready_p) got_q.push_back({2'd1, 1'b0, data_p, perr_p, ferr_p});
    if (valid_s && ready_s) got_q.push_back({2'd2, 2'b00, data_s, perr_s, ferr_s});
    if (valid_a) vcyc_a++;
    if (ovr_a || ovr_p || ovr_s) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word from the frame as sent on the line.
  function automatic rec_t model(input int idx, input logic [8:0] data, input logic pbit,
                                 input logic [1:0] stops);
    rec_t r;
    int   nd   = (idx == 2) ? 7 : 8;
    int   ones = 0;
    r.idx  = 2'(idx);
    r.data = '0;
    for (int i = 0; i < nd; i++) begin
      r.data[i] = data[i];
      ones += int'(data[i]);
    end
    r.perr = (idx == 1) && (((ones + int'(pbit)) % 2) != PAR_ODD);
    r.ferr = (stops[0] == 1'b0) || (idx == 2 && stops[1] == 1'b0);
    return r;
  endfunction

  task automatic set_line(input int idx, input logic v);
    case (idx)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_s = v;
    endcase
  endtask

  // One bit period; optionally a single-clock inverted glitch near the bit centre.
  task automatic hold_bit(input int idx, input logic v, input bit glitch);
    for (int c = 0; c < CYC; c++) begin
      set_line(idx, (glitch && c == CYC / 2) ? ~v : v);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int idx, input int n);
    set_line(idx, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int idx, input logic [8:0] data, input logic pbit,
                       input logic [1:0] stops, input int glitch_bit, input bit expect_word);
    int nd = (idx == 2) ? 7 : 8;
    hold_bit(idx, 1'b0, 1'b0);
    for (int i = 0; i < nd; i++) hold_bit(idx, data[i], i == glitch_bit);
    if (idx == 1) hold_bit(idx, pbit, 1'b0);
    hold_bit(idx, stops[0], 1'b0);
    if (idx == 2) hold_bit(idx, stops[1], 1'b0);
    if (expect_word) exp_q.push_back(model(idx, data, pbit, stops));
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [8:0] d;
    rst = 1'b1;
    rx_a = 1'b1; rx_p = 1'b1; rx_s = 1'b1;
    ready_a = 1'b1; ready_p = 1'b1; ready_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_data",  32'(data_a), 0);
    chk("rst_flags", {29'd0, perr_a, ferr_a, ovr_a}, 0);
    rst = 1'b0;
    idle(0, 20);
    vcyc_a = 0;

    // Plain 8N1 word; valid must be a single-cycle pulse with ready high.
    frame(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b1);
    idle(0, 20);
    check_words("a5_8n1");
    chk("a5_valid_cycles", 32'(vcyc_a), 1);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right.
    frame(1, 9'h007, 1'b0, 2'b11, -1, 1'b1);
    idle(1, 20);
    frame(1, 9'h007, 1'b1, 2'b11, -1, 1'b1);
    idle(1, 20);
    check_words("par_07");

    // 7N2 with the second stop bit low.
    frame(2, 9'h055, 1'b0, 2'b01, -1, 1'b1);
    idle(2, 20);
    check_words("stop2_55");

    // Short start pulse is rejected; a one-clock glitch in data bit 3 is outvoted.
    set_line(0, 1'b0);
    repeat (3) @(negedge clk);
    idle(0, 3 * CYC);
    check_words("false_start");
    frame(0, 9'h000, 1'b0, 2'b11, 3, 1'b1);
    idle(0, 20);
    check_words("glitch_00");

    // Holding register full: second back-to-back word is dropped with one overrun pulse.
    ready_a = 1'b0;
    ovr_cnt = 0;
    frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b0);
    frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b0);
    idle(0, 20);
    chk("ovr_held_data", 32'(data_a), 32'h11);
    chk("ovr_held_valid", 32'(valid_a), 1);
    chk("ovr_pulses", 32'(ovr_cnt), 1);
    @(posedge clk);
    #1 ready_a = 1'b1;
    exp_q.push_back(model(0, 9'h011, 1'b0, 2'b11));
    @(negedge clk);
    chk("ovr_accept_valid", 32'(valid_a), 1);
    @(negedge clk);
    chk("ovr_clear_valid", 32'(valid_a), 0);
    check_words("ovr_accept");

    // Reset during data bit 4 clears a held word and discards the partial frame.
    ready_a = 1'b0;
    frame(0, 9'h081, 1'b0, 2'b11, -1, 1'b0);
    idle(0, 20);
    chk("rst_pre_valid", 32'(valid_a), 1);
    d = 9'($urandom_range(255));
    hold_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(0, d[i], 1'b0);
    set_line(0, d[4]);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(valid_a), 0);
    chk("midrst_data", 32'(data_a), 0);
    rst = 1'b0;
    ready_a = 1'b1;
    idle(0, 3 * CYC);
    check_words("midrst_discard");
    frame(0, 9'h03C, 1'b0, 2'b11, -1, 1'b1);
    idle(0, 20);
    check_words("after_rst_3c");

    // Break: one all-zero word with frame error, then re-arm only after line goes high.
    set_line(0, 1'b0);
    repeat (15 * CYC) @(negedge clk);
    exp_q.push_back(model(0, 9'h000, 1'b0, 2'b00));
    idle(0, 3 * CYC);
    check_words("break");

    // Random frames on all three formats.
    for (int k = 0; k < 6; k++) begin
      d = 9'($urandom_range(511));
      frame(0, d, 1'b0, ($urandom_range(3) == 0) ? 2'b00 : 2'b11, -1, 1'b1);
      idle(0, 20);
      frame(1, 9'($urandom_range(511)), 1'($urandom_range(1)),
            ($urandom_range(3) == 0) ? 2'b00 : 2'b11, -1, 1'b1);
      idle(1, 20);
      frame(2, 9'($urandom_range(511)), 1'b0, 2'($urandom_range(3)), -1, 1'b1);
      idle(2, 20);
      check_words("random");
    end
    chk("no_stray_overrun", 32'(ovr_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised successor to the fixed 8N1 UART receiver.
- Adds configurable frame format: data width, optional parity, 1 or 2 stop bits.
- Adds 3-sample majority voting at bit centre, false-start rejection, and parity/framing/overrun error reporting.
- Sits between the board rx pin and the byte consumer, using the existing valid/ready handshake.

Parameters:
- CLK_FRE, 27: clock frequency in MHz.
- BAUD_RATE, 115200: serial baud rate.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rx_pin  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_BITS  received word, LSB first on line.
- rx_data_valid  out  1  rx_data and error flags are valid.
- rx_data_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity mismatch for the word presented; qualified by rx_data_valid.
- frame_err  out  1  a stop bit was sampled low; qualified by rx_data_valid.
- overrun_err  out  1  one-cycle pulse: a frame completed while the holding register was still full.

Behaviour:
- One clock domain; reset is synchronous and active-high on clk.
- Reset: all outputs 0; state IDLE; counters 0; synchroniser flops 1.
- Derived constant: CYCLE = CLK_FRE*1000000/BAUD_RATE. Elaboration error if CYCLE < 8, DATA_BITS is outside 5..9, or STOP_BITS is not 1 or 2.
- rx_pin passes through a 2-flop synchroniser, reset to 1. Falling edge = previous synchronised value 1, current value 0.
- cycle_cnt counts 0..CYCLE-1 within each bit period and clears on every state change.
- Majority vote: the synchronised line is sampled at cycle_cnt = CYCLE/2-1, CYCLE/2 and CYCLE/2+1. The bit value is the majority of the three, decided at CYCLE/2+1.
- States and transitions:
  - IDLE: on falling edge -> START (cycle_cnt=0).
  - START: if the vote = 1 -> IDLE (false start, no output, no error). Otherwise -> DATA at cycle_cnt=CYCLE-1.
  - DATA: bit_cnt runs 0..DATA_BITS-1. Voted bit is written to rx_bits[bit_cnt]. At cycle_cnt=CYCLE-1 and bit_cnt=DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: voted bit is stored; -> STOP at cycle_cnt=CYCLE-1.
  - STOP: stop_cnt runs 0..STOP_BITS-1. Any stop bit voted 0 sets the frame-error flag.
    - Non-final stop bit: move to the next stop bit at CYCLE-1.
    - Final stop bit: at its decision point -> DELIVER. This is mid-bit, so a back-to-back start edge is not missed.
  - DELIVER (single cycle):
    - Holding register empty (rx_data_valid=0): load rx_data, parity_err and frame_err; set rx_data_valid.
    - Holding register full: drop the new word, pulse overrun_err for 1 cycle, leave the held word and flags unchanged.
    - Then -> IDLE.
- Parity check: parity_err = (XOR of data bits XOR parity bit) != PARITY_ODD. parity_err is always 0 when PARITY_EN=0.
- Handshake:
  - rx_data_valid stays high until a cycle with rx_data_valid && rx_data_ready. It clears on the next edge.
  - Clear and a new load in the same DELIVER cycle: the load wins, valid stays 1, and there is no overrun.
  - Reception continues while valid is high; the receiver is never back-pressured.
- Latency: rx_data_valid rises 1 clk after the DELIVER decision. From the rx_pin start edge: 2 (synchroniser) + 1 (edge detect) + bit periods to the final stop-bit centre + 2.
- Reset mid-frame: return to IDLE on the next edge; the partial word is discarded and rx_data_valid is cleared.
- A frame error still delivers the word, with frame_err=1. A break condition (line held low) yields one word of zeros with frame_err=1, then waits for the line to return high before edge detection re-arms.

Decomposition:
- uart_pkg holds:
  - typedef enum uart_rx_state_t {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DELIVER};
  - function calc_cycle(clk_fre, baud) shared with the transmitter;
  - localparam limits for DATA_BITS and STOP_BITS.
- One sub-module, uart_rx_sampler: synchroniser, edge detect and 3-sample majority voter, driven by cycle_cnt. Its outputs are fall_edge, bit_val and bit_strobe.

Test Plan:
- CLK_FRE=1, BAUD_RATE=100000 (CYCLE=10), defaults, ready=1; send 0xA5 8N1 -> rx_data=0xA5, valid high for 1 cycle, parity_err=0, frame_err=0.
- PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity bit 0 -> parity_err=1. Resend with parity bit 1 -> parity_err=0.
- DATA_BITS=7, STOP_BITS=2; send 0x55 with second stop bit low -> rx_data=0x55, frame_err=1.
- Start pulse low for 3 clk only -> no rx_data_valid and state back in IDLE. Then a 1-clk glitch mid data bit 3 of 0x00 -> rx_data=0x00 (majority rejects the glitch).
- ready=0; send 0x11 then 0x22 back-to-back -> rx_data holds 0x11, overrun_err pulses once. Raise ready -> valid clears the next cycle.
- Assert rst during data bit 4 -> outputs 0 next edge. A following 0x3C frame is received correctly.
